frame_hdr_extract: RTL and testbench

Consumer stage sitting directly behind the switch-core ingress interface mux. It pops frame descriptors and frame bytes from the mux's shared data/pointer FIFOs, captures DA/SA from the first 12 bytes into a lookup request, and streams every byte with SOF/EOF marks into the packet-buffer write port. Runt frames (length < 12) are read out and discarded. Backpressure is applied at frame granularity.

---
 rtl/frame_hdr_extract_if.sv | 34 +++
 rtl/frame_hdr_extract.sv | 245 ++++++++++++++++++++++++
 tb/tb_frame_hdr_extract.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_hdr_extract_if.sv
// Bus bundle between the ingress mux FIFOs, the header extractor, the packet
// buffer write port and the lookup request channel.
interface frame_hdr_extract_if;
    logic        ptr_sfifo_empty;
    logic        ptr_sfifo_rd;
    logic [15:0] ptr_sfifo_dout;
    logic        sfifo_rd;
    logic [7:0]  sfifo_dout;
    logic        pkt_bp;
    logic        pkt_wr;
    logic [7:0]  pkt_din;
    logic        pkt_sof;
    logic        pkt_eof;
    logic        hdr_req;
    logic        hdr_ack;
    logic [47:0] hdr_da;
    logic [47:0] hdr_sa;
    logic [3:0]  hdr_src;
    logic [10:0] hdr_len;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    modport master (
        input  ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, pkt_bp, hdr_ack,
        output ptr_sfifo_rd, sfifo_rd, pkt_wr, pkt_din, pkt_sof, pkt_eof,
               hdr_req, hdr_da, hdr_sa, hdr_src, hdr_len, frame_cnt, drop_cnt
    );

    modport slave (
        output ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, pkt_bp, hdr_ack,
        input  ptr_sfifo_rd, sfifo_rd, pkt_wr, pkt_din, pkt_sof, pkt_eof,
               hdr_req, hdr_da, hdr_sa, hdr_src, hdr_len, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/frame_hdr_extract.sv
// Frame header extractor: pops descriptors and bytes from the ingress mux FIFOs,
// streams bytes with SOF/EOF to the packet buffer and raises a DA/SA lookup request.
module frame_hdr_extract #(
    parameter int MIN_LEN = 12
) (
    input  logic                clk_sys,
    input  logic                rstn_sys,
    frame_hdr_extract_if.master bus
);
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PTR_RD  = 3'd1,
        PTR_LAT = 3'd2,
        DATA    = 3'd3,
        DRAIN0  = 3'd4,
        DRAIN1  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [10:0] desc_len_s;
    logic [3:0]  desc_src_s;
    logic        desc_drop_s;
    logic        start_s;
    logic        unused_rsvd_s;

    logic        ptr_rd_r;
    logic        data_rd_r;
    logic [10:0] rd_cnt_r;
    logic [10:0] len_r;
    logic        drop_r;

    logic        cap_vld_r;
    logic [10:0] idx_r;
    logic        fwd_s;
    logic        fwd_first_s;
    logic        fwd_last_s;
    logic        fwd_hdr_done_s;

    logic        pkt_wr_r;
    logic [7:0]  pkt_din_r;
    logic        pkt_sof_r;
    logic        pkt_eof_r;
    logic        hdr_req_r;
    logic [47:0] hdr_da_r;
    logic [47:0] hdr_sa_r;
    logic [3:0]  hdr_src_r;
    logic [10:0] hdr_len_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] drop_cnt_r;

    assign desc_len_s    = bus.ptr_sfifo_dout[10:0];
    assign desc_src_s    = bus.ptr_sfifo_dout[14:11];
    assign desc_drop_s   = (desc_len_s < MIN_LEN_C);
    assign unused_rsvd_s = bus.ptr_sfifo_dout[15];

    // A new frame is only started once the previous lookup has been accepted.
    assign start_s = !bus.ptr_sfifo_empty && !bus.pkt_bp && !hdr_req_r;

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = PTR_RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PTR_RD: begin
                state_nxt_s = PTR_LAT;
            end
            PTR_LAT: begin
                if (desc_len_s == 11'd0) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            DATA: begin
                if (rd_cnt_r == 11'd1) begin
                    state_nxt_s = DRAIN0;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            DRAIN0: begin
                state_nxt_s = DRAIN1;
            end
            DRAIN1: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Byte-stage qualifiers: the byte in sfifo_dout now has index idx_r.
    always_comb begin
        fwd_s          = cap_vld_r && !drop_r;
        fwd_first_s    = fwd_s && (idx_r == 11'd0);
        fwd_last_s     = fwd_s && (idx_r == (len_r - 11'd1));
        fwd_hdr_done_s = fwd_s && (idx_r == 11'd11);
    end

    // Sequencer state register.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO pop strobes are registered from the next state so they align with PTR_RD/DATA.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            ptr_rd_r  <= 1'b0;
            data_rd_r <= 1'b0;
        end else begin
            ptr_rd_r  <= (state_nxt_s == PTR_RD);
            data_rd_r <= (state_nxt_s == DATA);
        end
    end

    // Descriptor latch and data pop down-counter.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            len_r    <= 11'd0;
            drop_r   <= 1'b0;
            rd_cnt_r <= 11'd0;
        end else if (state_r == PTR_LAT) begin
            len_r    <= desc_len_s;
            drop_r   <= desc_drop_s;
            rd_cnt_r <= desc_len_s;
        end else if (state_r == DATA) begin
            rd_cnt_r <= rd_cnt_r - 11'd1;
        end else begin
            rd_cnt_r <= rd_cnt_r;
        end
    end

    // Capture stage: marks the cycle a popped byte is present on sfifo_dout.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            cap_vld_r <= 1'b0;
            idx_r     <= 11'd0;
        end else begin
            cap_vld_r <= data_rd_r;
            if (state_r == PTR_LAT) begin
                idx_r <= 11'd0;
            end else if (cap_vld_r) begin
                idx_r <= idx_r + 11'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Packet buffer write port.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            pkt_wr_r  <= 1'b0;
            pkt_din_r <= 8'd0;
            pkt_sof_r <= 1'b0;
            pkt_eof_r <= 1'b0;
        end else begin
            pkt_wr_r  <= fwd_s;
            pkt_sof_r <= fwd_first_s;
            pkt_eof_r <= fwd_last_s;
            if (fwd_s) begin
                pkt_din_r <= bus.sfifo_dout;
            end else begin
                pkt_din_r <= pkt_din_r;
            end
        end
    end

    // Header fields; untouched by runt frames so a pending lookup keeps its values.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            hdr_da_r  <= 48'd0;
            hdr_sa_r  <= 48'd0;
            hdr_src_r <= 4'd0;
            hdr_len_r <= 11'd0;
        end else begin
            if ((state_r == PTR_LAT) && !desc_drop_s) begin
                hdr_src_r <= desc_src_s;
                hdr_len_r <= desc_len_s;
            end
            if (fwd_s && (idx_r < 11'd6)) begin
                hdr_da_r <= {hdr_da_r[39:0], bus.sfifo_dout};
            end else if (fwd_s && (idx_r < 11'd12)) begin
                hdr_sa_r <= {hdr_sa_r[39:0], bus.sfifo_dout};
            end
        end
    end

    // Lookup request: rises with the last SA byte, drops after an accepted ack.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            hdr_req_r <= 1'b0;
        end else if (hdr_req_r && bus.hdr_ack) begin
            hdr_req_r <= 1'b0;
        end else if (fwd_hdr_done_s) begin
            hdr_req_r <= 1'b1;
        end else begin
            hdr_req_r <= hdr_req_r;
        end
    end

    // Forwarded and dropped frame counters, free-running with wrap.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            frame_cnt_r <= 16'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            if (fwd_last_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if ((state_r == PTR_LAT) && desc_drop_s) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign bus.ptr_sfifo_rd = ptr_rd_r;
    assign bus.sfifo_rd     = data_rd_r;
    assign bus.pkt_wr       = pkt_wr_r;
    assign bus.pkt_din      = pkt_din_r;
    assign bus.pkt_sof      = pkt_sof_r;
    assign bus.pkt_eof      = pkt_eof_r;
    assign bus.hdr_req      = hdr_req_r;
    assign bus.hdr_da       = hdr_da_r;
    assign bus.hdr_sa       = hdr_sa_r;
    assign bus.hdr_src      = hdr_src_r;
    assign bus.hdr_len      = hdr_len_r;
    assign bus.frame_cnt    = frame_cnt_r;
    assign bus.drop_cnt     = drop_cnt_r;
endmodule

// File: tb/tb_frame_hdr_extract.sv
// Directed bench for frame_hdr_extract: FIFO models feed frames, a monitor logs
// the output side, and one linear initial block checks the logs.
module tb_frame_hdr_extract;
    logic clk_sys  = 1'b0;
    logic rstn_sys = 1'b0;
    int   cyc      = 0;

    frame_hdr_extract_if bus();

    frame_hdr_extract #(.MIN_LEN(12)) dut (
        .clk_sys  (clk_sys),
        .rstn_sys (rstn_sys),
        .bus      (bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Upstream FIFO storage, written by the stimulus, read by the FIFO model.
    logic [15:0] desc_mem [32];
    logic [7:0]  data_mem [4096];
    logic [4:0]  desc_wp = 5'd0;
    logic [4:0]  desc_rp = 5'd0;
    logic [11:0] data_wp = 12'd0;
    logic [11:0] data_rp = 12'd0;
    logic        ack_auto = 1'b1;
    logic        ack_man  = 1'b0;

    assign bus.ptr_sfifo_empty = (desc_rp == desc_wp);
    assign bus.hdr_ack = ack_auto ? bus.hdr_req : ack_man;

    always @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            desc_rp            <= desc_wp;
            data_rp            <= data_wp;
            bus.ptr_sfifo_dout <= 16'h0000;
            bus.sfifo_dout     <= 8'h00;
        end else begin
            if (bus.ptr_sfifo_rd) begin
                bus.ptr_sfifo_dout <= desc_mem[desc_rp];
                desc_rp            <= desc_rp + 5'd1;
            end
            if (bus.sfifo_rd) begin
                bus.sfifo_dout <= data_mem[data_rp];
                data_rp        <= data_rp + 12'd1;
            end
        end
    end

    // Output monitor.
    int           ptr_cyc_q [$];
    int           rd_start_q[$];
    int           sof_cyc_q [$];
    int           req_cyc_q [$];
    logic [7:0]   wr_q      [$];
    logic         sof_q     [$];
    logic         eof_q     [$];
    logic [47:0]  da_q      [$];
    logic [47:0]  sa_q      [$];
    logic [3:0]   src_q     [$];
    logic [10:0]  len_q     [$];
    int           rd_total  = 0;
    int           req_hi    = 0;
    int           stab_err  = 0;
    logic         rd_prev   = 1'b0;
    logic         req_prev  = 1'b0;
    logic [110:0] snap      = '0;

    always @(negedge clk_sys) begin
        if (bus.ptr_sfifo_rd) ptr_cyc_q.push_back(cyc);
        if (bus.sfifo_rd) begin
            rd_total <= rd_total + 1;
            if (!rd_prev) rd_start_q.push_back(cyc);
        end
        if (bus.pkt_wr) begin
            wr_q.push_back(bus.pkt_din);
            sof_q.push_back(bus.pkt_sof);
            eof_q.push_back(bus.pkt_eof);
            if (bus.pkt_sof) sof_cyc_q.push_back(cyc);
        end
        if (bus.hdr_req) begin
            req_hi <= req_hi + 1;
            if (!req_prev) begin
                req_cyc_q.push_back(cyc);
                da_q.push_back(bus.hdr_da);
                sa_q.push_back(bus.hdr_sa);
                src_q.push_back(bus.hdr_src);
                len_q.push_back(bus.hdr_len);
            end else if ({bus.hdr_da, bus.hdr_sa, bus.hdr_src, bus.hdr_len} !== snap) begin
                stab_err <= stab_err + 1;
            end
        end
        snap     <= {bus.hdr_da, bus.hdr_sa, bus.hdr_src, bus.hdr_len};
        rd_prev  <= bus.sfifo_rd;
        req_prev <= bus.hdr_req;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chki(string tag, int obs, int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] bval(int f, int i);
        return 8'(f * 37 + i * 7 + 3);
    endfunction

    function automatic logic [47:0] exp_mac(int f, int off);
        logic [47:0] m = 48'd0;
        for (int k = 0; k < 6; k++) m = {m[39:0], bval(f, off + k)};
        return m;
    endfunction

    task automatic push_frame(int f, int len, logic [3:0] src, logic rsvd);
        for (int i = 0; i < len; i++) data_mem[data_wp + 12'(i)] = bval(f, i);
        data_wp = data_wp + 12'(len);
        desc_mem[desc_wp] = {rsvd, src, 11'(len)};
        desc_wp = desc_wp + 5'd1;
    endtask

    task automatic chk_zero(string p);
        chk({p, "_ctl"}, 64'({bus.ptr_sfifo_rd, bus.sfifo_rd, bus.pkt_wr,
                              bus.pkt_sof, bus.pkt_eof, bus.hdr_req}), 64'd0);
        chk({p, "_din"}, 64'(bus.pkt_din), 64'd0);
        chk({p, "_da"},  64'(bus.hdr_da), 64'd0);
        chk({p, "_sa"},  64'(bus.hdr_sa), 64'd0);
        chk({p, "_srclen"}, 64'({bus.hdr_src, bus.hdr_len}), 64'd0);
        chk({p, "_cnts"}, 64'({bus.frame_cnt, bus.drop_cnt}), 64'd0);
    endtask

    // Bounded wait for frame_cnt to reach target; the final compare reports a timeout.
    task automatic wait_fcnt(string tag, int target, int budget);
        int n = 0;
        while (int'(bus.frame_cnt) != target && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        chki(tag, int'(bus.frame_cnt), target);
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic chk_frame(string tag, int f, int base, int len);
        int bad = 0;
        for (int i = 0; i < len; i++) begin
            if (wr_q[base + i] !== bval(f, i)) bad++;
            if (sof_q[base + i] !== (i == 0)) bad++;
            if (eof_q[base + i] !== (i == len - 1)) bad++;
        end
        chki(tag, bad, 0);
    endtask

    int p0, w0, r0, rs0, s0, rt0, rh0, n;

    initial begin
        bus.pkt_bp = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk_zero("rst");
        rstn_sys = 1'b1;
        repeat (3) @(negedge clk_sys);

        // 64-byte frame, immediate ack, reserved bit set
        p0 = ptr_cyc_q.size(); w0 = wr_q.size(); r0 = req_cyc_q.size();
        rs0 = rd_start_q.size(); s0 = sof_cyc_q.size(); rh0 = req_hi;
        push_frame(0, 64, 4'b0010, 1'b1);
        wait_fcnt("t1_fcnt", 1, 300);
        chki("t1_nwr", wr_q.size() - w0, 64);
        chk_frame("t1_bytes", 0, w0, 64);
        chk("t1_da", 64'(da_q[r0]), 64'(exp_mac(0, 0)));
        chk("t1_sa", 64'(sa_q[r0]), 64'(exp_mac(0, 6)));
        chk("t1_src", 64'(src_q[r0]), 64'd2);
        chk("t1_len", 64'(len_q[r0]), 64'd64);
        chki("t1_rd_lat", rd_start_q[rs0] - ptr_cyc_q[p0], 2);
        chki("t1_sof_lat", sof_cyc_q[s0] - ptr_cyc_q[p0], 4);
        chki("t1_req_lat", req_cyc_q[r0] - ptr_cyc_q[p0], 15);
        chki("t1_req_1cyc", req_hi - rh0, 1);
        chk("t1_drop", 64'(bus.drop_cnt), 64'd0);

        // runt of 8 then a 60-byte frame
        w0 = wr_q.size(); r0 = req_cyc_q.size(); rt0 = rd_total;
        push_frame(1, 8, 4'b0100, 1'b0);
        push_frame(2, 60, 4'b1000, 1'b0);
        wait_fcnt("t2_fcnt", 2, 400);
        chki("t2_rds", rd_total - rt0, 68);
        chk("t2_drop", 64'(bus.drop_cnt), 64'd1);
        chki("t2_nwr", wr_q.size() - w0, 60);
        chk_frame("t2_bytes", 2, w0, 60);
        chki("t2_nreq", req_cyc_q.size() - r0, 1);
        chk("t2_hdr", 64'({src_q[r0], len_q[r0]}), 64'({4'b1000, 11'd60}));
        chk("t2_da", 64'(da_q[r0]), 64'(exp_mac(2, 0)));

        // zero-length descriptor followed by a 20-byte frame
        p0 = ptr_cyc_q.size(); w0 = wr_q.size(); rt0 = rd_total;
        push_frame(3, 0, 4'b0001, 1'b0);
        push_frame(4, 20, 4'b0001, 1'b0);
        wait_fcnt("t3_fcnt", 3, 300);
        chki("t3_gap", ptr_cyc_q[p0 + 1] - ptr_cyc_q[p0], 3);
        chk("t3_drop", 64'(bus.drop_cnt), 64'd2);
        chki("t3_rds", rd_total - rt0, 20);
        chk_frame("t3_bytes", 4, w0, 20);

        // back-to-back 64 and 1518
        p0 = ptr_cyc_q.size(); w0 = wr_q.size(); r0 = req_cyc_q.size();
        push_frame(5, 64, 4'b0010, 1'b0);
        push_frame(6, 1518, 4'b0100, 1'b0);
        wait_fcnt("t4_fcnt", 5, 2000);
        chki("t4_gap", ptr_cyc_q[p0 + 1] - ptr_cyc_q[p0], 69);
        chk_frame("t4_bytes", 6, w0 + 64, 1518);
        chk("t4_len", 64'(len_q[r0 + 1]), 64'd1518);

        // lookup ack withheld for 200 cycles with a second descriptor pending
        ack_auto = 1'b0;
        p0 = ptr_cyc_q.size(); w0 = wr_q.size(); r0 = req_cyc_q.size();
        push_frame(7, 64, 4'b1000, 1'b0);
        push_frame(8, 16, 4'b0001, 1'b0);
        n = 0;
        while (req_cyc_q.size() == r0 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (200) @(negedge clk_sys);
        chk("t5_fcnt", 64'(bus.frame_cnt), 64'd6);
        chki("t5_nwr", wr_q.size() - w0, 64);
        chk("t5_req_held", 64'(bus.hdr_req), 64'd1);
        chki("t5_no_pop", ptr_cyc_q.size() - p0, 1);
        chk("t5_da_live", 64'(bus.hdr_da), 64'(exp_mac(7, 0)));
        chk("t5_sa_live", 64'(bus.hdr_sa), 64'(exp_mac(7, 6)));
        n = cyc;
        ack_man = 1'b1;
        @(negedge clk_sys);
        ack_man  = 1'b0;
        ack_auto = 1'b1;
        wait_fcnt("t5_fcnt2", 7, 300);
        chki("t5_pop_after_ack", ptr_cyc_q[p0 + 1], n + 2);
        chki("t5_stable", stab_err, 0);

        // backpressure with a 12-byte (minimum) frame pending
        bus.pkt_bp = 1'b1;
        p0 = ptr_cyc_q.size(); w0 = wr_q.size(); r0 = req_cyc_q.size();
        push_frame(9, 12, 4'b0010, 1'b0);
        repeat (10) @(negedge clk_sys);
        chki("t6_bp_hold", ptr_cyc_q.size() - p0, 0);
        n = cyc;
        bus.pkt_bp = 1'b0;
        wait_fcnt("t6_fcnt", 8, 200);
        chki("t6_pop_cyc", ptr_cyc_q[p0], n + 1);
        chk_frame("t6_bytes", 9, w0, 12);
        chki("t6_nreq", req_cyc_q.size() - r0, 1);

        // 11-byte runt, one below the minimum
        w0 = wr_q.size(); r0 = req_cyc_q.size();
        push_frame(10, 11, 4'b0100, 1'b0);
        n = 0;
        while (bus.drop_cnt != 16'd3 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (20) @(negedge clk_sys);
        chk("t6_runt_drop", 64'(bus.drop_cnt), 64'd3);
        chki("t6_runt_nwr", wr_q.size() - w0, 0);
        chki("t6_runt_nreq", req_cyc_q.size() - r0, 0);

        // asynchronous reset in the middle of a frame
        w0 = wr_q.size();
        push_frame(11, 64, 4'b0100, 1'b0);
        n = 0;
        while ((wr_q.size() - w0) < 30 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chki("t7_reached_30", wr_q.size() - w0, 30);
        #2;
        rstn_sys = 1'b0;
        #1;
        chk_zero("t7_rst");
        repeat (2) @(negedge clk_sys);
        rstn_sys = 1'b1;
        repeat (2) @(negedge clk_sys);
        w0 = wr_q.size();
        push_frame(12, 20, 4'b0001, 1'b0);
        wait_fcnt("t7_fcnt", 1, 200);
        chk_frame("t7_bytes", 12, w0, 20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
